cpu_mem_arbiter: RTL and testbench

CPU_MEM_ARBITER -- requirements
Module: cpu_mem_arbiter

---
 rtl/cpu_mem_arbiter_pkg.sv | 26 ++
 rtl/arb_perf_cnt.sv | 38 +++
 rtl/cpu_mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_cpu_mem_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_arbiter_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : cpu_mem_arbiter_pkg
// Brief    : Shared FSM encoding, request-source enum and counter constants
// Revision : 1.0
//------------------------------------------------------------------------------
package cpu_mem_arbiter_pkg;

    localparam int C_CNT_W = 32;
    localparam logic [C_CNT_W-1:0] C_CNT_ONE = 32'd1;

    // One-hot so each state flag is a single flop bit
    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_REQ   = 4'b0010,
        ST_WAIT  = 4'b0100,
        ST_DELIV = 4'b1000
    } state_t;

    typedef enum logic {
        SRC_INST = 1'b0,
        SRC_DATA = 1'b1
    } src_t;

endpackage
`default_nettype wire

// File: rtl/arb_perf_cnt.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : arb_perf_cnt
// Brief    : Four free-running 32-bit event counters for the arbiter
// Revision : 1.0
//------------------------------------------------------------------------------
module arb_perf_cnt
    import cpu_mem_arbiter_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               inc_inst_rd,
    input  logic               inc_data_rd,
    input  logic               inc_data_wr,
    input  logic               inc_stall,
    output logic [C_CNT_W-1:0] perf_inst_rd,
    output logic [C_CNT_W-1:0] perf_data_rd,
    output logic [C_CNT_W-1:0] perf_data_wr,
    output logic [C_CNT_W-1:0] perf_stall
);

    // Counters wrap naturally at 2^32
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_inst_rd <= '0;
            perf_data_rd <= '0;
            perf_data_wr <= '0;
            perf_stall   <= '0;
        end else begin
            if (inc_inst_rd) perf_inst_rd <= perf_inst_rd + C_CNT_ONE;
            if (inc_data_rd) perf_data_rd <= perf_data_rd + C_CNT_ONE;
            if (inc_data_wr) perf_data_wr <= perf_data_wr + C_CNT_ONE;
            if (inc_stall)   perf_stall   <= perf_stall   + C_CNT_ONE;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cpu_mem_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : cpu_mem_arbiter
// Brief    : Single-outstanding arbiter merging CPU fetch and data ports onto
//            one memory request/response channel. ARB_PERF_CNT_EN adds counters.
// Revision : 1.0
//------------------------------------------------------------------------------
module cpu_mem_arbiter
    import cpu_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   PC,
    input  logic                Inst_Req_Valid,
    output logic                Inst_Req_Ack,
    output logic [DATA_W-1:0]   Instruction,
    output logic                Inst_Valid,
    input  logic                Inst_Ack,
    input  logic [ADDR_W-1:0]   Address,
    input  logic                MemWrite,
    input  logic [DATA_W-1:0]   Write_data,
    input  logic [DATA_W/8-1:0] Write_strb,
    input  logic                MemRead,
    output logic                Mem_Req_Ack,
    output logic [DATA_W-1:0]   Read_data,
    output logic                Read_data_Valid,
    input  logic                Read_data_Ack,
    output logic                m_req_valid,
    input  logic                m_req_ready,
    output logic                m_req_wen,
    output logic [ADDR_W-1:0]   m_req_addr,
    output logic [DATA_W-1:0]   m_req_wdata,
    output logic [DATA_W/8-1:0] m_req_wstrb,
    input  logic                m_resp_valid,
    output logic                m_resp_ready,
    input  logic [DATA_W-1:0]   m_resp_data,
    output logic [31:0]         perf_inst_rd,
    output logic [31:0]         perf_data_rd,
    output logic [31:0]         perf_data_wr,
    output logic [31:0]         perf_stall
);

    state_t                r_state;
    src_t                  r_src;
    logic                  r_wen;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic [DATA_W/8-1:0]   r_wstrb;
    logic [DATA_W-1:0]     r_resp_buf;

    logic w_idle;
    logic w_data_req;
    logic w_deliv_ack;

    assign w_idle      = (r_state == ST_IDLE);
    assign w_data_req  = MemRead | MemWrite;
    assign Mem_Req_Ack  = w_idle & w_data_req;
    assign Inst_Req_Ack = w_idle & ~w_data_req & Inst_Req_Valid;
    // Only the ack belonging to the delivering source can close DELIV
    assign w_deliv_ack = (r_state == ST_DELIV) &
                         ((r_src == SRC_INST) ? Inst_Ack : Read_data_Ack);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_src      <= SRC_INST;
            r_wen      <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_resp_buf <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (Mem_Req_Ack) begin
                        r_addr  <= Address;
                        r_wdata <= Write_data;
                        r_wstrb <= Write_strb;
                        r_wen   <= MemWrite;
                        r_src   <= SRC_DATA;
                        r_state <= ST_REQ;
                    end else if (Inst_Req_Ack) begin
                        r_addr  <= PC;
                        r_wdata <= '0;
                        r_wstrb <= '0;
                        r_wen   <= 1'b0;
                        r_src   <= SRC_INST;
                        r_state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // Writes are posted: no response phase
                    if (m_req_ready) r_state <= r_wen ? ST_IDLE : ST_WAIT;
                end
                ST_WAIT: begin
                    if (m_resp_valid) begin
                        r_resp_buf <= m_resp_data;
                        r_state    <= ST_DELIV;
                    end
                end
                ST_DELIV: begin
                    if (w_deliv_ack) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign m_req_valid     = (r_state == ST_REQ);
    assign m_req_wen       = r_wen;
    assign m_req_addr      = r_addr;
    assign m_req_wdata     = r_wdata;
    assign m_req_wstrb     = r_wstrb;
    assign m_resp_ready    = (r_state == ST_WAIT);
    assign Instruction     = r_resp_buf;
    assign Read_data       = r_resp_buf;
    assign Inst_Valid      = (r_state == ST_DELIV) & (r_src == SRC_INST);
    assign Read_data_Valid = (r_state == ST_DELIV) & (r_src == SRC_DATA);

`ifdef ARB_PERF_CNT_EN
    logic w_inc_inst_rd;
    logic w_inc_data_rd;
    logic w_inc_data_wr;
    logic w_inc_stall;

    assign w_inc_inst_rd = w_deliv_ack & (r_src == SRC_INST);
    assign w_inc_data_rd = w_deliv_ack & (r_src == SRC_DATA);
    assign w_inc_data_wr = m_req_valid & m_req_ready & r_wen;
    assign w_inc_stall   = (m_req_valid & ~m_req_ready) | (m_resp_ready & ~m_resp_valid);

    arb_perf_cnt u_perf_cnt (
        .clk          (clk),
        .rst_n        (rst_n),
        .inc_inst_rd  (w_inc_inst_rd),
        .inc_data_rd  (w_inc_data_rd),
        .inc_data_wr  (w_inc_data_wr),
        .inc_stall    (w_inc_stall),
        .perf_inst_rd (perf_inst_rd),
        .perf_data_rd (perf_data_rd),
        .perf_data_wr (perf_data_wr),
        .perf_stall   (perf_stall)
    );
`else
    assign perf_inst_rd = '0;
    assign perf_data_rd = '0;
    assign perf_data_wr = '0;
    assign perf_stall   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cpu_mem_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_cpu_mem_arbiter
// Brief    : Directed self-checking bench for cpu_mem_arbiter
// Revision : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cpu_mem_arbiter;

`ifdef ARB_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] PC;
    logic        Inst_Req_Valid;
    logic        Inst_Req_Ack;
    logic [31:0] Instruction;
    logic        Inst_Valid;
    logic        Inst_Ack;
    logic [31:0] Address;
    logic        MemWrite;
    logic [31:0] Write_data;
    logic [3:0]  Write_strb;
    logic        MemRead;
    logic        Mem_Req_Ack;
    logic [31:0] Read_data;
    logic        Read_data_Valid;
    logic        Read_data_Ack;
    logic        m_req_valid;
    logic        m_req_ready;
    logic        m_req_wen;
    logic [31:0] m_req_addr;
    logic [31:0] m_req_wdata;
    logic [3:0]  m_req_wstrb;
    logic        m_resp_valid;
    logic        m_resp_ready;
    logic [31:0] m_resp_data;
    logic [31:0] perf_inst_rd;
    logic [31:0] perf_data_rd;
    logic [31:0] perf_data_wr;
    logic [31:0] perf_stall;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] stall0;

    always #5 clk = ~clk;

    cpu_mem_arbiter dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .PC              (PC),
        .Inst_Req_Valid  (Inst_Req_Valid),
        .Inst_Req_Ack    (Inst_Req_Ack),
        .Instruction     (Instruction),
        .Inst_Valid      (Inst_Valid),
        .Inst_Ack        (Inst_Ack),
        .Address         (Address),
        .MemWrite        (MemWrite),
        .Write_data      (Write_data),
        .Write_strb      (Write_strb),
        .MemRead         (MemRead),
        .Mem_Req_Ack     (Mem_Req_Ack),
        .Read_data       (Read_data),
        .Read_data_Valid (Read_data_Valid),
        .Read_data_Ack   (Read_data_Ack),
        .m_req_valid     (m_req_valid),
        .m_req_ready     (m_req_ready),
        .m_req_wen       (m_req_wen),
        .m_req_addr      (m_req_addr),
        .m_req_wdata     (m_req_wdata),
        .m_req_wstrb     (m_req_wstrb),
        .m_resp_valid    (m_resp_valid),
        .m_resp_ready    (m_resp_ready),
        .m_resp_data     (m_resp_data),
        .perf_inst_rd    (perf_inst_rd),
        .perf_data_rd    (perf_data_rd),
        .perf_data_wr    (perf_data_wr),
        .perf_stall      (perf_stall)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive point: just after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pexp(input int n);
        return PERF ? 32'(n) : 32'd0;
    endfunction

    initial begin
        rst_n = 1'b0;
        PC = '0; Inst_Req_Valid = 0; Inst_Ack = 0;
        Address = '0; MemWrite = 0; Write_data = '0; Write_strb = '0; MemRead = 0;
        Read_data_Ack = 0; m_req_ready = 0; m_resp_valid = 0; m_resp_data = '0;

        tick(); tick();
        @(negedge clk);
        check("rst_req_valid", m_req_valid, 0);
        check("rst_resp_ready", m_resp_ready, 0);
        check("rst_inst_valid", Inst_Valid, 0);
        check("rst_rd_valid", Read_data_Valid, 0);
        check("rst_rdata", Read_data, 0);
        check("rst_addr", m_req_addr, 0);
        check("rst_perf_stall", perf_stall, 0);
        tick();
        rst_n = 1'b1;

        // Fetch: PC=0x100, response after 2 WAIT cycles
        tick();
        PC = 32'h100; Inst_Req_Valid = 1;
        @(negedge clk);
        check("f_inst_ack", Inst_Req_Ack, 1);
        check("f_mem_ack", Mem_Req_Ack, 0);
        tick();
        Inst_Req_Valid = 0; m_req_ready = 1;
        @(negedge clk);
        check("f_req_valid", m_req_valid, 1);
        check("f_req_addr", m_req_addr, 32'h100);
        check("f_req_wen", m_req_wen, 0);
        check("f_req_wstrb", m_req_wstrb, 0);
        tick();
        m_req_ready = 0;
        @(negedge clk);
        check("f_resp_ready", m_resp_ready, 1);
        check("f_no_valid_yet", Inst_Valid, 0);
        tick();
        m_resp_valid = 1; m_resp_data = 32'h0000_0013;
        tick();
        m_resp_valid = 0; m_resp_data = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("f_inst_valid", Inst_Valid, 1);
            check("f_instruction", Instruction, 32'h13);
            check("f_rd_valid_off", Read_data_Valid, 0);
            tick();
        end
        Inst_Ack = 1;
        tick();
        Inst_Ack = 0;
        @(negedge clk);
        check("f_inst_valid_clr", Inst_Valid, 0);
        check("f_perf_inst", perf_inst_rd, pexp(1));

        // Store: posted write
        tick();
        Address = 32'h200; Write_data = 32'hDEAD_BEEF; Write_strb = 4'b0011;
        MemWrite = 1; m_req_ready = 1;
        @(negedge clk);
        check("s_mem_ack", Mem_Req_Ack, 1);
        tick();
        MemWrite = 0; Address = '0; Write_data = '0; Write_strb = '0;
        @(negedge clk);
        check("s_req_valid", m_req_valid, 1);
        check("s_req_wen", m_req_wen, 1);
        check("s_req_addr", m_req_addr, 32'h200);
        check("s_req_wdata", m_req_wdata, 32'hDEAD_BEEF);
        check("s_req_wstrb", m_req_wstrb, 4'b0011);
        tick();
        m_req_ready = 0;
        @(negedge clk);
        check("s_req_done", m_req_valid, 0);
        check("s_no_rd_valid", Read_data_Valid, 0);
        check("s_no_resp_ready", m_resp_ready, 0);
        check("s_perf_wr", perf_data_wr, pexp(1));

        // Collision: load wins, fetch waits; then delayed ack
        tick();
        Address = 32'h300; MemRead = 1; PC = 32'h104; Inst_Req_Valid = 1; m_req_ready = 1;
        @(negedge clk);
        check("c_mem_ack", Mem_Req_Ack, 1);
        check("c_inst_ack", Inst_Req_Ack, 0);
        tick();
        MemRead = 0;
        @(negedge clk);
        check("c_req_addr", m_req_addr, 32'h300);
        check("c_req_wen", m_req_wen, 0);
        check("c_inst_ack_req", Inst_Req_Ack, 0);
        tick();
        m_req_ready = 0; m_resp_valid = 1; m_resp_data = 32'hCAFE_F00D;
        tick();
        m_resp_valid = 0;
        // Three cycles after the request ack
        for (int i = 0; i < 10; i++) begin
            if (i == 4) Inst_Ack = 1;
            if (i == 6) begin m_resp_valid = 1; m_resp_data = 32'h1111_2222; end
            @(negedge clk);
            check("d_rd_valid", Read_data_Valid, 1);
            check("d_rdata", Read_data, 32'hCAFE_F00D);
            check("d_inst_valid", Inst_Valid, 0);
            check("d_inst_req_ack", Inst_Req_Ack, 0);
            tick();
            Inst_Ack = 0; m_resp_valid = 0;
        end
        Read_data_Ack = 1;
        @(negedge clk);
        check("d_no_ack_in_deliv", Inst_Req_Ack, 0);
        tick();
        Read_data_Ack = 0;
        @(negedge clk);
        check("d_rd_valid_clr", Read_data_Valid, 0);
        check("c_inst_ack_late", Inst_Req_Ack, 1);
        check("d_perf_rd", perf_data_rd, pexp(1));
        tick();
        Inst_Req_Valid = 0; m_req_ready = 1;
        @(negedge clk);
        check("c_fetch_addr", m_req_addr, 32'h104);
        tick();
        m_req_ready = 0; m_resp_valid = 1; m_resp_data = 32'h0000_0093;
        tick();
        m_resp_valid = 0;
        @(negedge clk);
        check("c_fetch_valid", Inst_Valid, 1);
        check("c_fetch_data", Instruction, 32'h93);
        Inst_Ack = 1;
        tick();
        Inst_Ack = 0;
        @(negedge clk);
        check("c_perf_inst", perf_inst_rd, pexp(2));

        // Backpressure: ready low for 5 cycles
        stall0 = perf_stall;
        tick();
        Address = 32'h400; Write_data = 32'h1234_5678; Write_strb = 4'hF; MemWrite = 1;
        tick();
        MemWrite = 0; Address = 32'hFFFF_FFFC; Write_data = 32'h0; Write_strb = 4'h0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("b_req_valid", m_req_valid, 1);
            check("b_req_addr", m_req_addr, 32'h400);
            check("b_req_wdata", m_req_wdata, 32'h1234_5678);
            check("b_req_wstrb", m_req_wstrb, 4'hF);
            tick();
        end
        m_req_ready = 1;
        @(negedge clk);
        check("b_req_valid_last", m_req_valid, 1);
        tick();
        m_req_ready = 0;
        @(negedge clk);
        check("b_req_done", m_req_valid, 0);
        check("b_perf_stall", perf_stall - stall0, pexp(5));
        check("b_perf_wr", perf_data_wr, pexp(2));

        // Reset while in WAIT, then late response
        tick();
        Address = 32'h500; MemRead = 1; m_req_ready = 1;
        tick();
        MemRead = 0;
        tick();
        m_req_ready = 0;
        @(negedge clk);
        check("r_in_wait", m_resp_ready, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("r_async_resp_ready", m_resp_ready, 0);
        check("r_async_addr", m_req_addr, 0);
        check("r_async_perf_rd", perf_data_rd, 0);
        tick();
        rst_n = 1'b1; m_resp_valid = 1; m_resp_data = 32'h0000_0BAD;
        @(negedge clk);
        check("r_resp_ready_idle", m_resp_ready, 0);
        tick();
        m_resp_valid = 0;
        @(negedge clk);
        check("r_no_rd_valid", Read_data_Valid, 0);
        check("r_no_inst_valid", Inst_Valid, 0);
        check("r_rdata_clr", Read_data, 0);
        tick();
        Inst_Req_Valid = 1; PC = 32'h108;
        @(negedge clk);
        check("r_idle_accepts", Inst_Req_Ack, 1);
        tick();
        Inst_Req_Valid = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
